// File: rtl/audio_out_scheduler.sv
// audio_out_scheduler
// Time-shares the Audio_Controller output FIFO between NUM_SRC sound-effect
// sources and the mic passthrough. Once per output frame it visits each
// source slot in order and accumulates the enabled samples. It then applies
// the master volume shift, adds the mic sample when one is available,
// saturates, and issues one write_audio_out (with read_audio_in in MIX).
module audio_out_scheduler #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 32
) (
  input  logic                        CLOCK_50,
  input  logic                        resetn,
  input  logic [NUM_SRC-1:0]          src_enable,
  input  logic [NUM_SRC-1:0]          src_valid,
  input  logic [NUM_SRC*DATA_W-1:0]   src_sample,
  output logic [NUM_SRC-1:0]          src_ready,
  input  logic [2:0]                  volume_shift,
  input  logic                        mic_en,
  input  logic                        clear_underrun,
  input  logic                        audio_out_allowed,
  input  logic                        audio_in_available,
  input  logic [DATA_W-1:0]           left_channel_audio_in,
  input  logic [DATA_W-1:0]           right_channel_audio_in,
  output logic                        read_audio_in,
  output logic                        write_audio_out,
  output logic [DATA_W-1:0]           left_channel_audio_out,
  output logic [DATA_W-1:0]           right_channel_audio_out,
  output logic                        underrun,
  output logic                        busy,
  output logic [15:0]                 frame_cnt
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  // Four guard bits: 8 full-scale sources plus the mic cannot overflow.
  localparam int ACC_W = DATA_W + 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SRC - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_MIX     = 2'd2,
    S_WRITE   = 2'd3
  } state_t;

  // Sign-extend a DATA_W sample to accumulator width.
  function automatic logic signed [ACC_W-1:0] sext(input logic [DATA_W-1:0] x);
    sext = {{(ACC_W-DATA_W){x[DATA_W-1]}}, x};
  endfunction

  // Clamp an accumulator-width value to the signed DATA_W range.
  function automatic logic [DATA_W-1:0] sat(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] hi;
    logic signed [ACC_W-1:0] lo;
    hi = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    lo = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    if (v > hi) begin
      sat = hi[DATA_W-1:0];
    end else if (v < lo) begin
      sat = lo[DATA_W-1:0];
    end else begin
      sat = v[DATA_W-1:0];
    end
  endfunction

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0]        left_q, left_d;
  logic [DATA_W-1:0]        right_q, right_d;
  logic                     underrun_q, underrun_d;
  logic                     busy_q;
  logic [15:0]              frame_cnt_q, frame_cnt_d;

  logic [DATA_W-1:0]        samples_s [NUM_SRC];
  logic                     slot_take_s;
  logic                     slot_miss_s;
  logic                     mic_take_s;
  logic signed [ACC_W-1:0]  mix_s;
  logic signed [ACC_W-1:0]  mic_l_s;
  logic signed [ACC_W-1:0]  mic_r_s;

  // Unpack the flat sample bus into one word per source.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      samples_s[i] = src_sample[i*DATA_W +: DATA_W];
    end
  end

  // Per-slot handshake, underrun detection and the volume/mic mix terms.
  always_comb begin
    slot_take_s = (state_q == S_COLLECT) && src_enable[idx_q] && src_valid[idx_q];
    slot_miss_s = (state_q == S_COLLECT) && src_enable[idx_q] && !src_valid[idx_q];
    mic_take_s  = (state_q == S_MIX) && mic_en && audio_in_available;
    mix_s       = acc_q >>> volume_shift;
    if (mic_take_s) begin
      mic_l_s = sext(left_channel_audio_in);
      mic_r_s = sext(right_channel_audio_in);
    end else begin
      mic_l_s = {ACC_W{1'b0}};
      mic_r_s = {ACC_W{1'b0}};
    end
  end

  // One-hot ready toward the source currently being polled.
  always_comb begin
    src_ready = {NUM_SRC{1'b0}};
    if (slot_take_s) begin
      src_ready[idx_q] = 1'b1;
    end else begin
      src_ready = {NUM_SRC{1'b0}};
    end
  end

  // FIFO strobes: mic pop in MIX, output push in WRITE when space exists.
  always_comb begin
    read_audio_in   = mic_take_s;
    write_audio_out = (state_q == S_WRITE) && audio_out_allowed;
  end

  // Next-state logic for the frame FSM and its datapath registers.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    left_d      = left_q;
    right_d     = right_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (audio_out_allowed) begin
          state_d = S_COLLECT;
          idx_d   = {IDX_W{1'b0}};
          acc_d   = {ACC_W{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_COLLECT: begin
        if (slot_take_s) begin
          acc_d = acc_q + sext(samples_s[idx_q]);
        end else begin
          acc_d = acc_q;
        end
        if (idx_q == LAST_IDX) begin
          state_d = S_MIX;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_MIX: begin
        left_d  = sat(mix_s + mic_l_s);
        right_d = sat(mix_s + mic_r_s);
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (audio_out_allowed) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = S_IDLE;
        end else begin
          state_d = S_WRITE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sticky underrun: a miss in the current slot outranks a clear request.
  always_comb begin
    if (slot_miss_s) begin
      underrun_d = 1'b1;
    end else if (clear_underrun) begin
      underrun_d = 1'b0;
    end else begin
      underrun_d = underrun_q;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      idx_q       <= {IDX_W{1'b0}};
      acc_q       <= {ACC_W{1'b0}};
      left_q      <= {DATA_W{1'b0}};
      right_q     <= {DATA_W{1'b0}};
      underrun_q  <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      left_q      <= left_d;
      right_q     <= right_d;
      underrun_q  <= underrun_d;
      busy_q      <= (state_d != S_IDLE);
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign left_channel_audio_out  = left_q;
  assign right_channel_audio_out = right_q;
  assign underrun                = underrun_q;
  assign busy                    = busy_q;
  assign frame_cnt               = frame_cnt_q;

endmodule
